// File: rtl/pattern_gen_pkg.sv
// Shared types and constants for the pattern_gen test-data source.
// Imported by the top, the LFSR sub-module and the bench.
package pattern_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_SEQ   = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_CONST = 2'd3
  } mode_e;

  localparam int STALL_W = 16;

  // Saturating increment for the stall counter.
  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pattern_gen_if.sv
// Word handshake between pattern_gen (master) and its sink, e.g. a FIFO write port.
interface pattern_gen_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] d_out;
  logic              d_valid;
  logic              d_ready;

  modport master (output d_out, output d_valid, input d_ready);
  modport slave  (input d_out, input d_valid, output d_ready);
endinterface

// File: rtl/pattern_lfsr.sv
// Galois LFSR: shifts right, XORs the tap mask when the bit shifted out is 1.
// A zero seed would lock up, so it is replaced by 1.
module pattern_lfsr #(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(8'hB8),
  parameter logic [DATA_W-1:0] SEED      = DATA_W'(8'h01)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  output logic [DATA_W-1:0] q
);

  localparam logic [DATA_W-1:0] START = (SEED == '0) ? DATA_W'(1) : SEED;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     q <= START;
    else if (load) q <= START;
    else if (step) q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : '0);
  end

endmodule

// File: rtl/pattern_gen.sv
// Parametrised word source: step sequence, ramp, LFSR or constant words,
// one per programmable gap, handed over with valid/ready; finite or endless bursts.
module pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                GAP       = 2,
  parameter int                BURST_LEN = 0,
  parameter logic [DATA_W-1:0] BASE      = DATA_W'(8'h0A),
  parameter int                INC       = 2,
  parameter int                SEQ_LEN   = 3,
  parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(8'hB8),
  parameter logic [DATA_W-1:0] SEED      = DATA_W'(8'h01)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         mode,
  pattern_gen_if.master      bus,
  output logic               done,
  output logic               leden,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_GAP  = ST_GAP;
  localparam logic [1:0] S_SEND = ST_SEND;

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int SW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);
  localparam logic [SW-1:0] SEQ_LAST  = SW'(SEQ_LEN - 1);
  localparam logic [31:0]   WORD_LAST = 32'(BURST_LEN - 1);

  logic [1:0]        state, state_next;
  logic [GW-1:0]     gap_cnt;
  logic [31:0]       word_cnt;
  mode_e             mode_q;
  logic [SW-1:0]     seq_idx;
  logic [DATA_W-1:0] ramp;
  logic [DATA_W-1:0] lfsr_q;
  logic [DATA_W-1:0] pat_val;
  logic              accept;
  logic              burst_end;

  assign accept    = (state == S_SEND) && bus.d_ready;
  assign burst_end = accept && (BURST_LEN != 0) && (word_cnt == WORD_LAST);

  pattern_lfsr #(
    .DATA_W    (DATA_W),
    .LFSR_TAPS (LFSR_TAPS),
    .SEED      (SEED)
  ) u_lfsr (
    .clock (clock),
    .reset (reset),
    .load  (burst_end),
    .step  (accept && (mode_q == MODE_LFSR)),
    .q     (lfsr_q)
  );

  always_comb begin
    pat_val = BASE;
    case (mode_q)
      MODE_SEQ:   pat_val = BASE + DATA_W'(seq_idx) * DATA_W'(INC);
      MODE_RAMP:  pat_val = ramp;
      MODE_LFSR:  pat_val = lfsr_q;
      MODE_CONST: pat_val = BASE;
      default:    pat_val = BASE;
    endcase
  end

  // A pending word always completes; enable is only looked at after accept.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (enable) state_next = S_GAP;
      S_GAP: begin
        if (!enable)                  state_next = S_IDLE;
        else if (gap_cnt == GAP_LAST) state_next = S_SEND;
      end
      S_SEND: begin
        if (bus.d_ready) begin
          if (burst_end || !enable) state_next = S_IDLE;
          else                      state_next = S_GAP;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      gap_cnt     <= '0;
      word_cnt    <= '0;
      mode_q      <= MODE_SEQ;
      seq_idx     <= '0;
      ramp        <= '0;
      bus.d_out   <= '0;
      bus.d_valid <= 1'b0;
      done        <= 1'b0;
      leden       <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      state <= state_next;
      leden <= (state_next != S_IDLE);
      done  <= burst_end;
      case (state)
        S_IDLE: begin
          if (enable) begin
            gap_cnt <= '0;
            mode_q  <= mode_e'(mode);
            // Stall count belongs to a burst; resuming a paused stream keeps it.
            if (word_cnt == '0) stall_cnt <= '0;
          end
        end
        S_GAP: begin
          if (!enable) begin
            gap_cnt <= '0;
          end else if (gap_cnt == GAP_LAST) begin
            bus.d_out   <= pat_val;
            bus.d_valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        S_SEND: begin
          if (!bus.d_ready) begin
            stall_cnt <= sat_inc(stall_cnt);
          end else begin
            bus.d_valid <= 1'b0;
            gap_cnt     <= '0;
            if (burst_end) begin
              // Restart every pattern so the next burst repeats exactly.
              word_cnt <= '0;
              seq_idx  <= '0;
              ramp     <= '0;
            end else begin
              word_cnt <= word_cnt + 1'b1;
              if (mode_q == MODE_SEQ)
                seq_idx <= (seq_idx == SEQ_LAST) ? '0 : seq_idx + 1'b1;
              if (mode_q == MODE_RAMP)
                ramp <= ramp + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
